// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  // Receive FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;

  typedef logic [DATA_BITS-1:0] ps2_byte_t;

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic odd_parity_ok(input ps2_byte_t b, input logic p);
    return ^{b, p};
  endfunction

endpackage

// File: rtl/ps2_rx_if.sv
// Byte-delivery bus from the PS/2 receiver to the LED controller.
interface ps2_rx_if;
  import ps2_pkg::*;

  ps2_byte_t scancode;
  logic      scan_ready;
  logic      parity_err;
  logic      frame_err;

  // Receiver drives the bus.
  modport master (
    output scancode,
    output scan_ready,
    output parity_err,
    output frame_err
  );

  // Downstream consumer samples the bus.
  modport slave (
    input scancode,
    input scan_ready,
    input parity_err,
    input frame_err
  );

endinterface

// File: rtl/ps2_filter.sv
// Pin conditioning for PS/2: synchronizers, clock glitch filter, falling-edge
// bit strobe and a data bit delayed to line up with the filtered clock.
module ps2_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic CLK50MHZ,
  input  logic RST,
  input  logic PS2_CLK,
  input  logic PS2_DATA,
  output logic strobe,
  output logic data
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

  logic [1:0]            clk_sync;
  logic [1:0]            data_sync;
  logic                  clk_filt;
  logic [CNT_W-1:0]      filt_cnt;
  logic [FILTER_LEN-1:0] data_dly;

  // Two-flop synchronizers on both raw pins; idle level of the bus is high.
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], PS2_CLK};
      data_sync <= {data_sync[0], PS2_DATA};
    end
  end

  // Glitch filter: flip the filtered clock only after FILTER_LEN consecutive
  // differing samples; flag the 1->0 flip as a bit strobe in the same cycle.
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      strobe   <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == CNT_W'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
        strobe   <= clk_filt;
      end else begin
        filt_cnt <= filt_cnt + CNT_W'(1);
      end
    end
  end

  // Delay synchronized data by the filter depth so it is sampled with the strobe.
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      data_dly <= '1;
    end else begin
      data_dly <= FILTER_LEN'({data_dly, data_sync[1]});
    end
  end

  assign data = data_dly[FILTER_LEN-1];

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd
// parity, stop. Good bytes are presented with a one-cycle scan_ready strobe;
// parity, stop-bit and stall failures raise one-cycle error strobes instead.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic      CLK50MHZ,
  input  logic      RST,
  input  logic      PS2_CLK,
  input  logic      PS2_DATA,
  ps2_rx_if.master  bus
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned BIT_W = 3;

  logic             bit_strobe;
  logic             bit_data;

  ps2_state_e       state;
  ps2_state_e       state_nxt;
  logic [BIT_W-1:0] bit_cnt;
  logic [BIT_W-1:0] bit_cnt_nxt;
  ps2_byte_t        shift_q;
  ps2_byte_t        shift_nxt;
  logic             parity_q;
  logic             parity_nxt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_nxt;
  ps2_byte_t        scancode_q;
  ps2_byte_t        scancode_nxt;
  logic             scan_ready_q;
  logic             scan_ready_nxt;
  logic             parity_err_q;
  logic             parity_err_nxt;
  logic             frame_err_q;
  logic             frame_err_nxt;
  logic             timeout_c;

  ps2_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .CLK50MHZ (CLK50MHZ),
    .RST      (RST),
    .PS2_CLK  (PS2_CLK),
    .PS2_DATA (PS2_DATA),
    .strobe   (bit_strobe),
    .data     (bit_data)
  );

  // A partial frame has stalled when no strobe arrives for the full budget.
  assign timeout_c = (state != IDLE) && !bit_strobe &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // FSM state register.
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic; a stall from any in-frame state returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bit_strobe && (bit_data == START_BIT)) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (bit_strobe && (bit_cnt == BIT_W'(DATA_BITS - 1))) begin
          state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (bit_strobe) begin
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_strobe) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (timeout_c) begin
      state_nxt = IDLE;
    end
  end

  // FSM output/datapath logic: shift, parity capture, frame verdict, timeout.
  always_comb begin
    bit_cnt_nxt    = bit_cnt;
    shift_nxt      = shift_q;
    parity_nxt     = parity_q;
    scancode_nxt   = scancode_q;
    scan_ready_nxt = 1'b0;
    parity_err_nxt = 1'b0;
    frame_err_nxt  = 1'b0;

    if (bit_strobe || (state == IDLE) || timeout_c) begin
      tmo_nxt = '0;
    end else begin
      tmo_nxt = tmo_cnt + TMO_W'(1);
    end

    case (state)
      IDLE: begin
        if (bit_strobe && (bit_data == START_BIT)) begin
          bit_cnt_nxt = '0;
        end
      end
      DATA: begin
        if (bit_strobe) begin
          shift_nxt   = {bit_data, shift_q[DATA_BITS-1:1]};
          bit_cnt_nxt = bit_cnt + BIT_W'(1);
        end
      end
      PARITY: begin
        if (bit_strobe) begin
          parity_nxt = bit_data;
        end
      end
      STOP: begin
        if (bit_strobe) begin
          if (bit_data != STOP_BIT) begin
            frame_err_nxt = 1'b1;
          end else if (!odd_parity_ok(shift_q, parity_q)) begin
            parity_err_nxt = 1'b1;
          end else begin
            scancode_nxt   = shift_q;
            scan_ready_nxt = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (timeout_c) begin
      frame_err_nxt = 1'b1;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      bit_cnt      <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      tmo_cnt      <= '0;
      scancode_q   <= '0;
      scan_ready_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      bit_cnt      <= bit_cnt_nxt;
      shift_q      <= shift_nxt;
      parity_q     <= parity_nxt;
      tmo_cnt      <= tmo_nxt;
      scancode_q   <= scancode_nxt;
      scan_ready_q <= scan_ready_nxt;
      parity_err_q <= parity_err_nxt;
      frame_err_q  <= frame_err_nxt;
    end
  end

  assign bus.scancode   = scancode_q;
  assign bus.scan_ready = scan_ready_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: directed PS/2 frames, expected events queued by
// the driver, a negedge monitor pops and compares on every output pulse.
module tb_ps2_rx;

  localparam int unsigned FILTER_LEN = 8;
  localparam int unsigned TMO        = 400;
  localparam int          HALF       = 40;
  localparam int          LAT        = FILTER_LEN + 3;

  localparam int K_SCAN = 0;
  localparam int K_PERR = 1;
  localparam int K_FERR = 2;

  typedef struct {
    int         kind;
    logic [7:0] code;
    bit         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  int   cyc = 0;
  int   last_stop_fall = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic [7:0] model_code = 8'h00;
  bit   prev_any = 1'b0;
  exp_t q[$];

  ps2_rx_if bus ();

  ps2_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK50MHZ (clk),
    .RST      (rst),
    .PS2_CLK  (ps2_clk),
    .PS2_DATA (ps2_data),
    .bus      (bus)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input logic p, input logic s);
    return {s, p, b, 1'b0};
  endfunction

  task automatic expect_ev(input int kind, input logic [7:0] code, input bit lat);
    exp_t e;
    e.kind = kind;
    e.code = code;
    e.lat  = lat;
    q.push_back(e);
  endtask

  // Drive frame bits lo..hi; data changes while the clock is high.
  task automatic send_bits(input logic [10:0] fr, input int lo, input int hi, input int glitch_at);
    for (int i = lo; i <= hi; i++) begin
      ps2_data = fr[i];
      if (i == glitch_at) begin
        wait_cyc(10);
        ps2_clk = 1'b0;
        wait_cyc(5);
        ps2_clk = 1'b1;
        wait_cyc(HALF - 15);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk = 1'b0;
      if (i == 10) last_stop_fall = cyc;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  // Monitor: every output pulse must match the head of the expected queue.
  always @(negedge clk) begin
    bit any;
    int got_kind;
    exp_t e;
    any = bus.scan_ready | bus.parity_err | bus.frame_err;
    if (any) begin
      check("onehot", $countones({bus.scan_ready, bus.parity_err, bus.frame_err}), 1);
      check("single_cycle", int'(prev_any), 0);
      got_kind = bus.scan_ready ? K_SCAN : (bus.parity_err ? K_PERR : K_FERR);
      if (q.size() == 0) begin
        check("unexpected_pulse_kind", got_kind, -1);
      end else begin
        e = q.pop_front();
        check("event_kind", got_kind, e.kind);
        if (e.kind == K_SCAN) begin
          check("scancode", int'(bus.scancode), int'(e.code));
          model_code = e.code;
        end else begin
          check("scancode_hold", int'(bus.scancode), int'(model_code));
        end
        if (e.lat) check("latency", cyc - last_stop_fall, LAT);
      end
    end
    prev_any = any;
  end

  initial begin
    logic [10:0] fr;

    wait_cyc(4);
    check("rst_scancode", int'(bus.scancode), 0);
    check("rst_scan_ready", int'(bus.scan_ready), 0);
    check("rst_parity_err", int'(bus.parity_err), 0);
    check("rst_frame_err", int'(bus.frame_err), 0);
    rst = 1'b0;
    wait_cyc(20);

    // Good 0x1C (three ones, parity 0).
    expect_ev(K_SCAN, 8'h1C, 1'b1);
    send_bits(mk(8'h1C, 1'b0, 1'b1), 0, 10, -1);
    wait_cyc(30);

    // 0xF0 needs parity 1; send 0.
    expect_ev(K_PERR, 8'h00, 1'b1);
    send_bits(mk(8'hF0, 1'b0, 1'b1), 0, 10, -1);
    wait_cyc(30);

    // Bad stop bit, correct parity.
    expect_ev(K_FERR, 8'h00, 1'b1);
    send_bits(mk(8'h1C, 1'b0, 1'b0), 0, 10, -1);
    ps2_data = 1'b1;
    wait_cyc(30);

    // Short clock glitch while idle, then glitch inside a good 0x5A frame.
    ps2_clk = 1'b0;
    wait_cyc(5);
    ps2_clk = 1'b1;
    wait_cyc(40);
    expect_ev(K_SCAN, 8'h5A, 1'b1);
    send_bits(mk(8'h5A, 1'b1, 1'b1), 0, 10, 4);
    wait_cyc(30);

    // Start plus five data bits, then silence until the stall abort.
    expect_ev(K_FERR, 8'h00, 1'b0);
    send_bits(mk(8'h1C, 1'b0, 1'b1), 0, 5, -1);
    ps2_data = 1'b1;
    wait_cyc(TMO + 200);
    check("timeout_drained", q.size(), 0);
    expect_ev(K_SCAN, 8'hF0, 1'b1);
    send_bits(mk(8'hF0, 1'b1, 1'b1), 0, 10, -1);
    wait_cyc(30);

    // Reset after four data bits; the tail of 0xF0 is all ones so stays idle.
    fr = mk(8'hF0, 1'b1, 1'b1);
    send_bits(fr, 0, 4, -1);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    model_code = 8'h00;
    wait_cyc(1);
    check("midrst_scancode", int'(bus.scancode), 0);
    send_bits(fr, 5, 10, -1);
    expect_ev(K_SCAN, 8'h1C, 1'b1);
    send_bits(mk(8'h1C, 1'b0, 1'b1), 0, 10, -1);

    // Back-to-back frames with no gap.
    expect_ev(K_SCAN, 8'hF0, 1'b1);
    send_bits(mk(8'hF0, 1'b1, 1'b1), 0, 10, -1);
    expect_ev(K_SCAN, 8'h1C, 1'b1);
    send_bits(mk(8'h1C, 1'b0, 1'b1), 0, 10, -1);

    for (int i = 0; i < 3000 && q.size() != 0; i++) wait_cyc(1);
    check("queue_drained", q.size(), 0);
    wait_cyc(20);
    check("final_scancode", int'(bus.scancode), 8'h1C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
